scan_event_decoder: RTL and testbench

Receive-side decoder for the 2-D row/column scan pulse stream produced by the DCA scan sequencer. It tracks slot and row position from the step/row-end/done pulses and rebuilds, for every row, which columns carried an A-type and a B-type event. It checks start/end pairing and emits one record per row through a valid/ready output buffer. It sits downstream of the sequencer, next to the array driver, for monitoring and readback.

---
 rtl/scan_event_decoder_pkg.sv | 10 +
 rtl/scan_record_fifo.sv | 35 +++
 rtl/scan_event_decoder.sv | 149 ++++++++++++++
 tb/tb_scan_event_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/scan_event_decoder_pkg.sv
// scan_event_decoder_pkg: state encoding and record width helpers shared by the scan decoder
package scan_event_decoder_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int rec_w(input int rows, input int cols);
    return idx_w(rows) + 2 * cols;
  endfunction
endpackage

// File: rtl/scan_record_fifo.sv
// scan_record_fifo: 2-entry registered valid/ready buffer, accepts a push while full if popping
module scan_record_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         push_ok,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [2];
  logic rd, wr, pop, wr_en;
  logic [1:0] cnt;
  assign valid = cnt != 2'd0;
  assign pop = valid & ready;
  assign push_ok = (cnt != 2'd2) | pop;
  assign wr_en = push & push_ok;
  assign dout = mem[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (wr_en) mem[wr] <= din;
      wr <= wr ^ wr_en;
      rd <= rd ^ pop;
      cnt <= cnt + {1'b0, wr_en} - {1'b0, pop};
    end
endmodule

// File: rtl/scan_event_decoder.sv
// scan_event_decoder: rebuilds per-row A/B column masks from scan pulses and checks pairing
module scan_event_decoder
  import scan_event_decoder_pkg::*;
#(
  parameter int ROW_WIDTH = 8,
  parameter int COL_WIDTH = 8,
  parameter int ROW_IDX_W = idx_w(ROW_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 scan_start,
  input  logic                 a_start,
  input  logic                 b_start,
  input  logic                 a_end,
  input  logic                 b_end,
  input  logic                 slot_step,
  input  logic                 row_end,
  input  logic                 scan_done_in,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [ROW_IDX_W-1:0] rec_row,
  output logic [COL_WIDTH-1:0] rec_a_mask,
  output logic [COL_WIDTH-1:0] rec_b_mask,
  output logic                 busy,
  output logic                 scan_done,
  output logic                 proto_error,
  output logic                 overflow
);
  localparam int SLOT_W = $clog2(COL_WIDTH + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(COL_WIDTH);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROW_WIDTH - 1);
  typedef struct packed {
    logic [ROW_IDX_W-1:0] row;
    logic [COL_WIDTH-1:0] a_mask;
    logic [COL_WIDTH-1:0] b_mask;
  } rec_t;
  state_t state, state_n;
  logic [SLOT_W-1:0] slot, slot_n;
  logic [ROW_IDX_W-1:0] row, row_n;
  logic [COL_WIDTH-1:0] a_mask, a_mask_n, b_mask, b_mask_n, a_bit, b_bit;
  logic a_pend, a_pend_n, b_pend, b_pend_n, err, push, done_n, clr, push_ok;
  rec_t rec_in, rec_out;
  // Out-of-range shifts give zero, so slot COL_WIDTH sets no A bit and slot 0 sets no B bit
  assign a_bit = COL_WIDTH'(1) << slot;
  assign b_bit = COL_WIDTH'(1) << (slot - 1'b1);
  assign clr = enable & scan_start;
  always_comb begin
    state_n = state;
    slot_n = slot;
    row_n = row;
    a_mask_n = a_mask;
    b_mask_n = b_mask;
    a_pend_n = a_pend;
    b_pend_n = b_pend;
    err = 1'b0;
    push = 1'b0;
    done_n = 1'b0;
    rec_in = '0;
    if (clr) begin
      state_n = SCAN;
      slot_n = '0;
      row_n = '0;
      a_mask_n = '0;
      b_mask_n = '0;
      a_pend_n = 1'b0;
      b_pend_n = 1'b0;
    end else if (enable && state == SCAN) begin
      if (a_start) begin
        a_mask_n = a_mask_n | a_bit;
        err |= (slot == LAST_SLOT) | a_pend;
        a_pend_n = 1'b1;
      end
      if (a_end) begin
        err |= !a_pend & !a_start;
        a_pend_n = 1'b0;
      end
      if (b_start) begin
        b_mask_n = b_mask_n | b_bit;
        err |= (slot == '0) | b_pend;
        b_pend_n = 1'b1;
      end
      if (b_end) begin
        err |= !b_pend & !b_start;
        b_pend_n = 1'b0;
      end
      if (slot_step) begin
        err |= slot == LAST_SLOT;
        slot_n = slot == LAST_SLOT ? slot : slot + 1'b1;
      end
      if (row_end) begin
        err |= (slot != LAST_SLOT) | a_pend_n | b_pend_n | ((row == LAST_ROW) & !scan_done_in);
        push = 1'b1;
        rec_in = '{row: row, a_mask: a_mask_n, b_mask: b_mask_n};
        slot_n = '0;
        row_n = row == LAST_ROW ? '0 : row + 1'b1;
        a_mask_n = '0;
        b_mask_n = '0;
        a_pend_n = 1'b0;
        b_pend_n = 1'b0;
      end
      if (scan_done_in) begin
        err |= !row_end | (row != LAST_ROW);
        done_n = 1'b1;
        state_n = IDLE;
      end
    end else if (enable) begin
      err = a_start | a_end | b_start | b_end | slot_step | row_end | scan_done_in;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      slot <= '0;
      row <= '0;
      a_mask <= '0;
      b_mask <= '0;
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      scan_done <= 1'b0;
      proto_error <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      slot <= slot_n;
      row <= row_n;
      a_mask <= a_mask_n;
      b_mask <= b_mask_n;
      a_pend <= a_pend_n;
      b_pend <= b_pend_n;
      scan_done <= done_n;
      proto_error <= !clr & (proto_error | err);
      overflow <= !clr & (overflow | (push & !push_ok));
    end
  scan_record_fifo #(.W($bits(rec_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(rec_in),
    .push_ok(push_ok),
    .ready(rec_ready),
    .valid(rec_valid),
    .dout(rec_out)
  );
  assign busy = state == SCAN;
  assign rec_row = rec_out.row;
  assign rec_a_mask = rec_out.a_mask;
  assign rec_b_mask = rec_out.b_mask;
endmodule

// File: tb/tb_scan_event_decoder.sv
// tb_scan_event_decoder: vector table plus record scoreboard for the scan event decoder
module tb_scan_event_decoder;
  localparam logic [7:0] SS = 8'h80, AS = 8'h40, AE = 8'h20, BS = 8'h10;
  localparam logic [7:0] BE = 8'h08, ST = 8'h04, RE = 8'h02, DN = 8'h01;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, rec_ready = 1'b0;
  logic scan_start = 1'b0, a_start = 1'b0, a_end = 1'b0, b_start = 1'b0, b_end = 1'b0;
  logic slot_step = 1'b0, row_end = 1'b0, scan_done_in = 1'b0;
  logic rec_valid, busy, scan_done, proto_error, overflow;
  logic [1:0] rec_row;
  logic [3:0] rec_a_mask, rec_b_mask;
  int checks = 0, errors = 0;
  logic cur_en = 1'b1, cur_rdy = 1'b1, cur_ovf = 1'b0;
  typedef struct packed {
    logic [7:0] ev;
    logic en, rdy, err, bsy, done, ovf, push;
    logic [1:0] row;
    logic [3:0] a, b;
  } vec_t;
  typedef struct packed {
    logic [1:0] row;
    logic [3:0] a, b;
  } rec_t;
  vec_t tbl[$];
  rec_t exp_q[$];

  scan_event_decoder #(.ROW_WIDTH(4), .COL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .scan_start(scan_start),
    .a_start(a_start), .b_start(b_start), .a_end(a_end), .b_end(b_end),
    .slot_step(slot_step), .row_end(row_end), .scan_done_in(scan_done_in),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_row(rec_row),
    .rec_a_mask(rec_a_mask), .rec_b_mask(rec_b_mask), .busy(busy),
    .scan_done(scan_done), .proto_error(proto_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] ev, input logic err, input logic bsy,
                              input logic dn = 1'b0, input logic psh = 1'b0,
                              input logic [1:0] row = 2'd0, input logic [3:0] a = 4'd0,
                              input logic [3:0] b = 4'd0);
    vec_t t;
    t.ev = ev; t.en = cur_en; t.rdy = cur_rdy; t.err = err; t.bsy = bsy;
    t.done = dn; t.ovf = cur_ovf; t.push = psh; t.row = row; t.a = a; t.b = b;
    tbl.push_back(t);
  endfunction

  task automatic run(input string tag);
    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      enable = t.en;
      rec_ready = t.rdy;
      {scan_start, a_start, a_end, b_start, b_end, slot_step, row_end, scan_done_in} = t.ev;
      if (t.push) exp_q.push_back('{t.row, t.a, t.b});
      @(posedge clk);
      #1;
      {scan_start, a_start, a_end, b_start, b_end, slot_step, row_end, scan_done_in} = 8'd0;
      @(negedge clk);
      chk($sformatf("%s[%0d] proto_error", tag, i), proto_error, t.err);
      chk($sformatf("%s[%0d] busy", tag, i), busy, t.bsy);
      chk($sformatf("%s[%0d] scan_done", tag, i), scan_done, t.done);
      chk($sformatf("%s[%0d] overflow", tag, i), overflow, t.ovf);
    end
    tbl.delete();
  endtask

  task automatic drain(input string tag);
    rec_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk({tag, " records_outstanding"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, " rec_valid_after_drain"}, rec_valid, 0);
  endtask

  // Scoreboard: a record leaves the DUT at the edge following a valid&ready sample
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rec_valid && rec_ready) begin
        if (exp_q.size() == 0) chk("unexpected_record", rec_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("rec_row", rec_row, e.row);
          chk("rec_a_mask", rec_a_mask, e.a);
          chk("rec_b_mask", rec_b_mask, e.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset rec_valid", rec_valid, 0);
    chk("reset scan_done", scan_done, 0);
    chk("reset proto_error", proto_error, 0);
    chk("reset overflow", overflow, 0);
    chk("reset rec_row", rec_row, 0);
    chk("reset rec_masks", {rec_a_mask, rec_b_mask}, 0);
    rst = 1'b0;

    add(SS, 0, 1);
    add(AS, 0, 1); add(AE | ST, 0, 1); add(BS | BE | ST, 0, 1); add(AS | AE | ST, 0, 1); add(ST, 0, 1);
    add(RE, 0, 1, 0, 1, 2'd0, 4'b0101, 4'b0001);
    for (int r = 1; r < 4; r++) begin
      repeat (4) add(ST, 0, 1);
      add(r == 3 ? (RE | DN) : RE, 0, r != 3, r == 3, 1, r[1:0], 4'd0, 4'd0);
    end
    run("clean");
    drain("clean");

    cur_rdy = 1'b0;
    add(SS, 0, 1);
    for (int r = 0; r < 4; r++) begin
      if (r == 3) cur_rdy = 1'b1;
      repeat (4) add(ST, 0, 1);
      if (r == 2) cur_ovf = 1'b1;
      add(r == 3 ? (RE | DN) : RE, 0, r != 3, r == 3, r != 2, r[1:0], 4'd0, 4'd0);
    end
    run("backpressure");
    drain("backpressure");
    cur_ovf = 1'b0;

    add(SS, 0, 1); add(AE, 1, 1); add(SS, 0, 1); add(BS, 1, 1); add(SS, 0, 1);
    add(ST, 0, 1); add(ST, 0, 1); add(RE, 1, 1, 0, 1, 2'd0, 4'd0, 4'd0); add(SS, 0, 1);
    run("proto");
    drain("proto");

    add(SS, 0, 1); repeat (3) add(ST, 0, 1); add(AS | AE, 0, 1); add(ST, 0, 1);
    add(RE | BS | BE, 0, 1, 0, 1, 2'd0, 4'b1000, 4'b1000);
    repeat (4) add(ST, 0, 1); add(AS, 1, 1); add(SS, 0, 1);
    run("edge_slots");
    drain("edge_slots");

    cur_rdy = 1'b0;
    add(SS, 0, 1);
    cur_en = 1'b0;
    add(AS, 0, 1); repeat (5) add(ST, 0, 1); add(RE, 0, 1); add(SS, 0, 1); add(DN, 0, 1);
    cur_en = 1'b1;
    add(ST, 0, 1); add(AS | AE, 0, 1); repeat (3) add(ST, 0, 1);
    add(RE, 0, 1, 0, 1, 2'd0, 4'b0010, 4'd0);
    run("enable");
    chk("held rec_valid", rec_valid, 1);
    chk("held rec_row", rec_row, 0);
    chk("held rec_a_mask", rec_a_mask, 4'b0010);
    chk("held rec_b_mask", rec_b_mask, 4'b0000);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst rec_valid", rec_valid, 0);
    chk("midrst proto_error", proto_error, 0);
    chk("midrst overflow", overflow, 0);
    chk("midrst scan_done", scan_done, 0);
    chk("midrst rec_a_mask", rec_a_mask, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst busy", busy, 0);
    chk("post_rst rec_valid", rec_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
